// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the round datapath.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    localparam byte_t       RCON_INIT = 8'h01;
    localparam int unsigned NR        = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_e;

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic byte_t xtime(input byte_t b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1B) : {b[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, shared between SubWord and SubBytes.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_schedule.sv
// On-the-fly AES-128 key expansion: emits round keys 0..10 under a valid/ready handshake.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic         rk_valid_o,
    input  logic         ready_i,
    output logic [127:0] rk_o,
    output logic [3:0]   round_o,
    output logic         busy_o,
    output logic         done_o
);

    ks_state_e state_q, state_d;

    state_t rk_q;
    logic [3:0] round_q;
    byte_t rcon_q;
    logic rk_valid_q;
    logic done_q;

    logic load, advance, finish;
    logic accept;

    word_t w0, w1, w2, w3;
    word_t rot_w, sub_w, t_w;
    word_t n0, n1, n2, n3;
    state_t rk_next;

    // Next round key, derived combinationally from the current one.
    assign w0 = rk_q[31:0];
    assign w1 = rk_q[63:32];
    assign w2 = rk_q[95:64];
    assign w3 = rk_q[127:96];

    assign rot_w = {w3[7:0], w3[31:8]};

    genvar g;
    for (g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*g +: 8]),
            .out_byte (sub_w[8*g +: 8])
        );
    end

    assign t_w     = sub_w ^ {24'h000000, rcon_q};
    assign n0      = w0 ^ t_w;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign rk_next = {n3, n2, n1, n0};

    assign accept = rk_valid_q & ready_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (round_q == 4'(NR)) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rk_q       <= '0;
            round_q    <= '0;
            rcon_q     <= RCON_INIT;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                rk_q       <= key_i;
                round_q    <= '0;
                rcon_q     <= RCON_INIT;
                rk_valid_q <= 1'b1;
            end else if (advance) begin
                rk_q    <= rk_next;
                round_q <= round_q + 4'd1;
                rcon_q  <= xtime(rcon_q);
            end else if (finish) begin
                rk_valid_q <= 1'b0;
            end
        end
    end

    assign rk_o       = rk_q;
    assign round_o    = round_q;
    assign rk_valid_o = rk_valid_q;
    assign busy_o     = (state_q == RUN);
    assign done_o     = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule with a byte-level FIPS-197 expansion model.
module tb_aes_key_schedule;

    logic         clk_i = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [127:0] key_i;
    logic         rk_valid_o;
    logic         ready_i;
    logic [127:0] rk_o;
    logic [3:0]   round_o;
    logic         busy_o;
    logic         done_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] sbox_tab [256];
    bit         sbox_ready = 1'b0;

    aes_key_schedule dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .key_i      (key_i),
        .rk_valid_o (rk_valid_o),
        .ready_i    (ready_i),
        .rk_o       (rk_o),
        .round_o    (round_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // FIPS hex strings list the first byte leftmost; the DUT keeps byte 0 at [7:0].
    function automatic logic [127:0] fips(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) o[8*n +: 8] = s[8*(15-n) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [7:0] w [44][4];
        logic [7:0] t [4];
        logic [7:0] tmp;
        logic [7:0] rc;
        logic [127:0] o;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[i][j] = key[8*(4*i+j) +: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = tmp;
                for (int j = 0; j < 4; j++) t[j] = sbox_tab[t[j]];
                t[0] = t[0] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int n = 0; n < 16; n++) o[8*n +: 8] = w[4*r + n/4][n%4];
        return o;
    endfunction

    // Reference model: tracks handshake progress and expected key per round.
    logic [127:0] m_keys [11];
    bit m_run = 1'b0;
    bit m_valid = 1'b0;
    bit m_done = 1'b0;
    int m_round = 0;

    always @(negedge clk_i) begin
        if (!rst_n) begin
            chk("rst_rk", rk_o, '0);
            chk("rst_flags", {rk_valid_o, busy_o, done_o, round_o}, '0);
            m_run = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_round = 0;
        end else if (sbox_ready) begin
            chk("mon_valid", rk_valid_o, m_valid);
            chk("mon_done", done_o, m_done);
            chk("mon_busy", busy_o, m_run);
            chk("mon_excl", rk_valid_o & done_o, 0);
            if (m_valid) begin
                chk("mon_round", round_o, m_round[3:0]);
                chk("mon_rk", rk_o, m_keys[m_round]);
            end
            if (m_done) chk("mon_hold_rk", rk_o, m_keys[10]);
            m_done = 1'b0;
            if (!m_run) begin
                if (start_i) begin
                    for (int r = 0; r < 11; r++) m_keys[r] = round_key(key_i, r);
                    m_run = 1'b1; m_valid = 1'b1; m_round = 0;
                end
            end else if (ready_i) begin
                if (m_round == 10) begin
                    m_run = 1'b0; m_valid = 1'b0; m_done = 1'b1;
                end else begin
                    m_round++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_round(input int r, input int limit);
        int n = 0;
        while (!(rk_valid_o && round_o == 4'(r)) && n < limit) begin
            tick();
            n++;
        end
        chk($sformatf("reach_round%0d", r), {127'b0, rk_valid_o && round_o == 4'(r)}, 1);
    endtask

    task automatic wait_done(input int limit, input bit rand_ready);
        int n = 0;
        while (!done_o && n < limit) begin
            tick();
            if (rand_ready) ready_i = 1'($urandom_range(0, 1));
            n++;
        end
        chk("reach_done", done_o, 1);
    endtask

    task automatic start_key(input logic [127:0] k);
        start_i = 1'b1;
        key_i   = k;
        tick();
        start_i = 1'b0;
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        logic [7:0] inv;
        logic [7:0] s;
        rst_n = 1'b0; start_i = 1'b0; ready_i = 1'b0; key_i = '0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_tab[x] = s;
        end
        sbox_ready = 1'b1;

        chk("model_sbox_00", sbox_tab[8'h00], 8'h63);
        chk("model_sbox_53", sbox_tab[8'h53], 8'hed);
        chk("model_r1", round_key(fips(FIPS_KEY), 1), fips(FIPS_R1));
        chk("model_r10", round_key(fips(FIPS_KEY), 10), fips(FIPS_R10));
        chk("model_zero_r1", round_key('0, 1), fips(ZERO_R1));

        repeat (3) tick();
        chk("reset_rk", rk_o, '0);
        chk("reset_flags", {rk_valid_o, busy_o, done_o, round_o}, '0);
        rst_n = 1'b1;
        tick();

        // Full throughput: rounds 0..10 on consecutive cycles, done_o on the 12th.
        ready_i = 1'b1;
        start_key(fips(FIPS_KEY));
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk_i);
            chk($sformatf("tp_round%0d", k), {rk_valid_o, round_o}, {1'b1, 4'(k)});
            chk("tp_no_done", done_o, 0);
            if (k == 0) chk("tp_rk0", rk_o, fips(FIPS_KEY));
            if (k == 1) chk("tp_rk1", rk_o, fips(FIPS_R1));
            if (k == 9) chk("tp_rk9", rk_o, fips(FIPS_R9));
            if (k == 10) chk("tp_rk10", rk_o, fips(FIPS_R10));
        end
        @(negedge clk_i);
        chk("tp_done", {done_o, rk_valid_o, busy_o}, 3'b100);
        tick();

        // Random back-pressure; the model checks order and hold while stalled.
        ready_i = 1'($urandom_range(0, 1));
        start_key(fips(FIPS_KEY));
        wait_done(300, 1'b1);
        tick();

        // start_i with another key during round 4 must be ignored.
        ready_i = 1'b1;
        start_key(fips(FIPS_KEY));
        wait_round(4, 20);
        start_key(ALT_KEY);
        wait_done(20, 1'b0);
        chk("ign_rk10_hold", {round_o, rk_o}, {4'd10, fips(FIPS_R10)});
        tick();

        // Asynchronous reset in round 6 clears everything mid-cycle.
        start_key(fips(FIPS_KEY));
        wait_round(6, 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rk", rk_o, '0);
        chk("async_rst_flags", {rk_valid_o, busy_o, done_o, round_o}, '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        start_key('0);
        @(negedge clk_i);
        chk("zero_rk0", {round_o, rk_o}, {4'd0, 128'h0});
        @(negedge clk_i);
        chk("zero_rk1", {round_o, rk_o}, {4'd1, fips(ZERO_R1)});
        tick();
        wait_done(20, 1'b0);

        // Back-to-back: reload during the done_o cycle.
        start_i = 1'b1;
        key_i   = fips(FIPS_KEY);
        tick();
        start_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_rk0", {rk_valid_o, round_o, rk_o}, {1'b1, 4'd0, fips(FIPS_KEY)});
        tick();
        wait_done(20, 1'b0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

On-the-fly AES-128 key expansion engine feeding the AddRoundKey stage that follows MixColumn in the round datapath. It loads a 128-bit cipher key, emits round key 0 (the key itself), then derives round keys 1..10 one per accepted handshake. The valid/ready output lets the round controller stall key delivery without losing the expansion state. State byte packing matches the datapath: byte n of any 128-bit value sits at [8n+:8], and column c is [32c+:32].

## Interface
- No parameters; fixed at AES-128 (Nk=4, Nr=10).
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  load key_i and begin expansion; sampled only in IDLE.
- key_i  in  128  cipher key; byte 0 = first FIPS-197 key byte at [7:0].
- rk_valid_o  out  1  rk_o/round_o hold a valid round key.
- ready_i  in  1  consumer accepts the round key when rk_valid_o & ready_i.
- rk_o  out  128  current round key, same byte packing as key_i.
- round_o  out  4  index of rk_o, 0..10.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse after round 10 is accepted.

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN on start_i.
  - RUN → IDLE on acceptance while round_o == 10.
- Load in IDLE with start_i: rk_o <= key_i, round_o <= 0, rcon register <= 8'h01, rk_valid_o <= 1.
- Acceptance in RUN when round_o < 10:
  - rk_o <= next key, round_o += 1, rcon <= xtime(rcon).
  - rk_valid_o stays 1.
- Next key, with w_c = rk_o[32c+:32]:
  - t = SubWord(RotWord(w3)).
  - RotWord(w) = {w[7:0], w[31:8]}, i.e. bytes b0..b3 become b1,b2,b3,b0.
  - Rcon is XORed into byte 0 only: t[7:0] ^= rcon.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36. xtime = shift left 1, XOR 8'h1B if the MSB was set. All arithmetic is 8-bit, with no carry out.
- Acceptance at round_o == 10:
  - rk_valid_o <= 0, busy_o <= 0, done_o <= 1 for one cycle, FSM → IDLE.
  - rk_o and round_o hold their last values.
- When rk_valid_o = 1 and ready_i = 0, rk_o, round_o and rcon hold unchanged for any number of cycles.
- start_i in RUN is ignored; key_i is not re-sampled.
- start_i in the done_o cycle is legal: the FSM is already in IDLE, so a new load occurs at that edge.
- Reset value of every output is 0, with FSM in IDLE and rcon = 8'h01.
- Reset asserted mid-expansion aborts immediately. No partial key is retained.

## Timing
- start_i sampled at edge E gives rk_valid_o = 1 with round 0 from E.
- Full throughput: with ready_i held high, rounds 0..10 appear on 11 consecutive cycles, and done_o goes high in cycle 12.
- Next-key logic is combinational from the rk_o register: 4 S-box lookups plus XOR chain in one cycle.
- Outputs are registered; there is no combinational path from ready_i to any output.
- done_o and rk_valid_o are never high in the same cycle.

## Structure
- Shared package aes_pkg holds:
  - byte_t, word_t, state_t (logic [127:0]);
  - the xtime function, reused by MixColumn-style code;
  - RCON_INIT = 8'h01, NR = 10;
  - the FSM enum {IDLE, RUN}.
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4× for SubWord. It is shared with the SubBytes stage.

## Test plan
- Load FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with ready_i = 1:
  - round 0 = key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - done_o one cycle later.
- Same key, ready_i toggled pseudo-randomly: identical 11-key sequence in order, and rk_o/round_o stable whenever stalled.
- Assert start_i with a different key during round 4: ignored, and the original sequence completes unchanged.
- Assert rst_n low while round_o = 6: all outputs 0 asynchronously. After release, a new start with all-zero key gives round 1 = 62636363626363636263636362636363.
- Back-to-back: start_i high in the done_o cycle reloads the key, and round 0 appears next cycle.
- Rcon wrap: check the round 9 and round 10 keys of the FIPS key (ac7766f319fadc2128d12941575c006e, d014f9a8...) to confirm rcon values 1B and 36.
